// File: rtl/frame_timing_gen.sv
// rtl/frame_timing_gen.sv - audio frame timing generator: frame counter, voice-slot schedule, DAC bit/LR clocks
module frame_timing_gen #(
    parameter int FRAME_CYCLES = 384,
    parameter int N_VOICES     = 16,
    parameter int PIPE_DEPTH   = 1,
    parameter int BCLK_DIV     = 8,
    parameter int SLOT_BITS    = 24
) (
    input  logic                              sys_clk_i,
    input  logic                              reset_i,
    input  logic                              enable_i,
    input  logic                              sync_req_i,
    output logic [$clog2(FRAME_CYCLES)-1:0]   frame_cnt_o,
    output logic                              frame_start_o,
    output logic [15:0]                       frame_count_o,
    output logic [$clog2(N_VOICES+1)-1:0]     voice_idx_o,
    output logic                              voice_valid_o,
    output logic                              voice_last_o,
    output logic                              drain_o,
    output logic                              sample_clk_o,
    output logic                              lrclk_o,
    output logic                              bclk_o,
    output logic                              bit_strobe_o,
    output logic [$clog2(SLOT_BITS)-1:0]      bit_idx_o
);

    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int VW = $clog2(N_VOICES + 1);
    localparam int BW = $clog2(SLOT_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);

    if (FRAME_CYCLES != 2 * SLOT_BITS * BCLK_DIV || BCLK_DIV < 2 || (BCLK_DIV % 2) != 0 ||
        N_VOICES < 1 || N_VOICES + PIPE_DEPTH > FRAME_CYCLES) begin : g_bad_params
        $error("frame_timing_gen: inconsistent parameters");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic            first_q, first_d;
    logic [15:0]     fcount_q, fcount_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_d;
    logic            wrap;
    int              c;

    // Outputs are registered from the next count so every output matches the frame_cnt shown.
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        fcount_d = fcount_q;
        cnt_d    = '0;
        start_d  = 1'b0;
        wrap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                    wrap    = 1'b1;
                end
            end
            default: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (sync_req_i || cnt_q == LAST_CNT) begin
                    wrap = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        if (wrap) begin
            start_d = 1'b1;
            first_d = 1'b0;
            if (!first_q) begin
                fcount_d = fcount_q + 16'd1;
            end
        end
        c = int'(cnt_d);
    end

    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            first_q       <= 1'b1;
            fcount_q      <= '0;
            cnt_q         <= '0;
            frame_start_o <= 1'b0;
            voice_idx_o   <= VW'(N_VOICES);
            voice_valid_o <= 1'b0;
            voice_last_o  <= 1'b0;
            drain_o       <= 1'b0;
            sample_clk_o  <= 1'b1;
            lrclk_o       <= 1'b0;
            bclk_o        <= 1'b1;
            bit_strobe_o  <= 1'b0;
            bit_idx_o     <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            fcount_q <= fcount_d;
            if (state_d == RUN) begin
                cnt_q         <= cnt_d;
                frame_start_o <= start_d;
                voice_idx_o   <= (c < N_VOICES) ? VW'(c) : VW'(N_VOICES);
                voice_valid_o <= (c < N_VOICES);
                voice_last_o  <= (c == N_VOICES - 1);
                drain_o       <= (c >= N_VOICES) && (c < N_VOICES + PIPE_DEPTH);
                sample_clk_o  <= (c < FRAME_CYCLES / 2);
                lrclk_o       <= (c >= FRAME_CYCLES / 2);
                bclk_o        <= ((c % BCLK_DIV) < BCLK_DIV / 2);
                bit_strobe_o  <= ((c % BCLK_DIV) == 0);
                bit_idx_o     <= BW'((c / BCLK_DIV) % SLOT_BITS);
            end else begin
                cnt_q         <= '0;
                frame_start_o <= 1'b0;
                voice_idx_o   <= VW'(N_VOICES);
                voice_valid_o <= 1'b0;
                voice_last_o  <= 1'b0;
                drain_o       <= 1'b0;
                sample_clk_o  <= 1'b1;
                lrclk_o       <= 1'b0;
                bclk_o        <= 1'b1;
                bit_strobe_o  <= 1'b0;
                bit_idx_o     <= '0;
            end
        end
    end

    assign frame_cnt_o   = cnt_q;
    assign frame_count_o = fcount_q;

endmodule
